uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   UART receiver: the downstream stage of the transmitter on the serial link.
//   Oversamples the async serial line, frames 8N1 characters (start, 8 data LSB-first, stop),
//   and presents each byte with a one-cycle valid strobe; flags bad stop bits.
//   Generates its own oversample tick from the system clock; no external baud generator.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency, Hz
//   BAUD        9600        line rate, bits/s; must match the transmitter's baud_rate
//   OVERSAMPLE  16          samples per bit; even, >= 8
// PORTS
//   clk            in   1  system clock; all logic on rising edge
//   reset_n        in   1  asynchronous, active-low reset
//   serial_rx      in   1  async serial line, idle high
//   data_out       out  8  last correctly framed byte; held until next good frame
//   data_valid     out  1  1-cycle pulse: data_out updated this cycle
//   framing_error  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//   busy           out  1  high while a frame is in progress (START..STOP)
// BEHAVIOUR
//   Reset: data_out=0, data_valid=0, framing_error=0, busy=0, FSM=IDLE,
//     synchronizer flops=1, counters=0; reset_n low mid-frame aborts immediately, no pulses.
//   Input: 2-flop synchronizer on serial_rx (rx_s); all decisions use rx_s; 2-cycle input latency.
//   Tick: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated; counter 0..DIV-1, tick when ==DIV-1.
//     Counter cleared on the start-edge cycle so sampling phase aligns to the frame.
//   sample_cnt counts ticks 0..OVERSAMPLE-1; bit_idx 0..7.
//   FSM states IDLE, START, DATA, STOP:
//     IDLE : falling edge on rx_s (prev 1, now 0) -> START, busy=1, clear tick/sample counters.
//            Line held continuously low does NOT retrigger (edge-detect, not level).
//     START: at tick with sample_cnt==OVERSAMPLE/2-1 (mid start bit):
//            rx_s==0 -> DATA, sample_cnt=0, bit_idx=0; rx_s==1 -> false start, IDLE, busy=0.
//     DATA : at tick with sample_cnt==OVERSAMPLE-1 (centre of bit): shift rx_s in
//            LSB-first into shift reg, sample_cnt=0; after bit_idx==7 -> STOP.
//     STOP : at centre of stop bit: rx_s==1 -> data_out<=shift, data_valid=1;
//            rx_s==0 -> framing_error=1, data_out unchanged. Both -> IDLE, busy=0 same edge.
//   Pulses: data_valid/framing_error high exactly one clk, never both, never during reset.
//   Latency: pulse on the clk edge after the stop-bit-centre tick (~9.5 bit times after
//     start edge + 2 sync cycles).
//   Back-to-back: FSM is in IDLE from mid stop bit, so a start edge immediately after the
//     stop bit is caught; no idle gap required.
//   No backpressure: consumer must capture data_out on data_valid; a new frame overwrites it.
//   Break/stuck-low after framing error: IDLE waits for a rising then falling edge before
//     restarting.
// TESTING  (CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
//   1. Drive frame 0xA5, stop=1 -> one data_valid pulse, data_out=0xA5, framing_error=0,
//      busy high ~1520 clk.
//   2. Frames 0x00 then 0xFF with zero idle gap -> two data_valid pulses,
//      data_out 0x00 then 0xFF.
//   3. 40-clk low glitch on idle line -> busy pulses briefly, returns to IDLE,
//      no data_valid, no framing_error.
//   4. Frame 0x3C with stop=0, line low 5 more bits, then high, then frame 0x5A ->
//      framing_error pulse once, data_out keeps prior value, then valid 0x5A.
//   5. reset_n low during bit 3 of 0x81 -> all outputs reset at once, no pulse;
//      after release, frame 0x42 -> data_out=0x42.
//   6. Loopback from uart_tx at same BAUD, bytes 0x00..0xFF -> 256 valid pulses, values
//      match in order, no errors.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side output channel of the UART receiver: framed byte, its strobes, and frame status.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    // Receiver drives the channel.
    modport master (
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );

    // Consumer samples the channel.
    modport slave (
        input data_out,
        input data_valid,
        input framing_error,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with internal oversample tick generator, 2-flop input synchronizer,
// edge-triggered start detection, mid-bit sampling and stop-bit framing check.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      serial_rx,
    uart_rx_if.master rx_bus
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMP_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_HALF  = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic             fall;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       state;
    logic [SMP_W-1:0] sample_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= serial_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;
    assign tick = (div_cnt == DIV_LAST);

    // Oversample tick divider; restarted on the start edge so ticks are phase-aligned to the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if ((state == IDLE) && fall) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Frame FSM: validate start at mid bit, sample data/stop at bit centres, emit one-cycle strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state      <= START;
                        sample_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == SMP_HALF) begin
                            sample_cnt <= '0;
                            bit_idx    <= '0;
                            state      <= rx_s ? IDLE : DATA;
                        end else begin
                            sample_cnt <= sample_cnt + SMP_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == SMP_LAST) begin
                            sample_cnt <= '0;
                            shift      <= {rx_s, shift[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SMP_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sample_cnt == SMP_LAST) begin
                            sample_cnt <= '0;
                            state      <= IDLE;
                            if (rx_s) begin
                                data_q  <= shift;
                                valid_q <= 1'b1;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SMP_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_bus.data_out      = data_q;
    assign rx_bus.data_valid    = valid_q;
    assign rx_bus.framing_error = ferr_q;
    assign rx_bus.busy          = (state != IDLE);

endmodule
